instr_fetch_ctrl: RTL
=====================

# instr_fetch_ctrl

Instruction-fetch sequencer sitting between the `InstrMem` block RAM (1K x 32, one-cycle synchronous read) and the decode stage of KGP_miniRISC. It owns the fetch PC and drives the RAM address every cycle. It tracks the one-cycle read latency with an in-flight tag and buffers returned words in a 2-entry FIFO. It hands instructions to decode over a valid/ready handshake, and supports branch redirect and halt.

## Interface
- `ADDR_W`, 10, instruction word-address width; matches `InstrMem` `addra`.
- `DATA_W`, 32, instruction width; matches `InstrMem` `douta`.
- `RESET_PC`, 0, fetch PC loaded on reset.
- `clka` in 1: single clock, shared with `InstrMem`.
- `rst` in 1: synchronous, active-high reset.
- `mem_addr` out ADDR_W: RAM address, wired to `addra`; equals the fetch PC register.
- `mem_rdata` in DATA_W: RAM data, wired to `douta`.
- `instr` out DATA_W: head-of-FIFO instruction.
- `instr_pc` out ADDR_W: word address of `instr`.
- `instr_valid` out 1: FIFO non-empty.
- `instr_ready` in 1: decode accepts `instr` this cycle.
- `redirect` in 1: flush and restart fetch at `redirect_pc`.
- `redirect_pc` in ADDR_W: redirect target.
- `halt` in 1: stop issuing new reads while high.

## Operation
- **State:**
  - `fetch_pc` (drives `mem_addr`).
  - In-flight flag plus `inflight_pc`.
  - 2-entry FIFO of {pc, instr} with `count` in 0..2.
- **Per-cycle signals:**
  - `pop` = `instr_valid` & `instr_ready`.
  - `issue` = !`redirect` & !`halt` & ((`count` − `pop` + `inflight`) < 2).
- **At each edge, in priority order:**
  1. `rst`: `fetch_pc`=`RESET_PC`; `inflight`=0; `count`=0; FIFO pointers 0.
  2. `redirect`: `fetch_pc`=`redirect_pc`; `inflight`=0; `count`=0. Any simultaneous `pop` or returning word is discarded.
  3. Otherwise, all of:
     - If `inflight`: push {`inflight_pc`, `mem_rdata`}.
     - If `pop`: drop the head entry.
     - `inflight`=`issue`. If `issue`: `inflight_pc`=`fetch_pc` and `fetch_pc`=`fetch_pc`+1.
- **Arithmetic and FIFO rules:**
  - `fetch_pc` increments modulo 2^ADDR_W (1023 → 0, no flag).
  - Push and pop in the same cycle leave `count` unchanged.
  - The issue rule guarantees push never overflows.
- **Halt:** an in-flight read still completes and the FIFO still drains; `fetch_pc` holds. Deasserting `halt` resumes at the held `fetch_pc`.
- **Reset mid-operation:** the FIFO and any in-flight word are discarded. No stale word appears after reset.
- **Reset values:** `mem_addr`=`RESET_PC`, `instr_valid`=0. `instr` and `instr_pc` are 0 (FIFO storage cleared).

## Timing
- **RAM timing:** the RAM samples `mem_addr` at edge N. `mem_rdata` is valid during cycle N→N+1 and is captured into the FIFO at edge N+1.
- **Reset release:** `rst` low in cycle 0 gives `instr_valid`=1 with `instr`=mem[`RESET_PC`] in cycle 2.
- **Redirect latency:** `redirect` high in cycle 0 gives `mem_addr`=`redirect_pc` in cycle 1. `instr_valid` is 0 in cycles 1–2. The target instruction is valid in cycle 3.
- **Steady state:** with `instr_ready` held high, one instruction per cycle with consecutive `instr_pc`.
- **Backpressure:** `instr_ready` low → FIFO fills to 2, issue stops, `mem_addr` holds. Nothing is lost or duplicated. After `instr_ready` rises, the first new issue occurs in that same cycle.
- **Handshake rule:** `instr`, `instr_pc` and `instr_valid` change only after a pop or a flush.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds outputs `perf_fetched` [15:0] and `perf_stall` [15:0].
  - `perf_fetched` counts `pop` cycles.
  - `perf_stall` counts cycles with `instr_valid` & !`instr_ready`.
  - Both counters saturate at 16'hFFFF and clear on `rst` only; `redirect` does not clear them.
- Not defined: neither port nor counter logic exists; all other behaviour is identical.

## Test plan
For every scenario below, `InstrMem` is preloaded with mem[a] = 32'hA000_0000 | a.

- **Reset release:** release reset, `instr_ready`=1 → cycle 2 shows `instr`=32'hA000_0000 and `instr_pc`=0. Then `instr_pc` shows 1, 2, 3… on consecutive cycles with no gaps.
- **Backpressure:** hold `instr_ready`=0 for 5 cycles starting at `instr_pc`=4 → `count` saturates at 2 and `mem_addr` holds at 6. On release, decode receives 4, 5, 6, 7 with no duplicates or skips.
- **Redirect:** assert `redirect` with `redirect_pc`=10'h200 while valid and ready → pending words are dropped. Next valid (3 cycles later) is `instr`=32'hA000_0200 with `instr_pc`=10'h200.
- **Wrap-around:** redirect to 10'h3FE → sequence 3FE, 3FF, 000, 001, with data matching the address.
- **Halt:** assert `halt` for 6 cycles with `instr_ready`=1 → at most 2 further words are delivered, then `instr_valid`=0 and `mem_addr` is constant. Release resumes at the next sequential PC.
- **Mid-run reset (with `FETCH_PERF_CNT_EN`):**
  - `rst` pulse mid-run → `instr_valid`=0 the next cycle, and the first post-reset `instr_pc` is 0.
  - `perf_fetched` equals the accepted count and `perf_stall` equals the observed stall cycles. Both read 0 after `rst`.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, tracks one in-flight RAM read and buffers words in a 2-entry FIFO.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_stall saturating counters.
module instr_fetch_ctrl #(
    parameter int                ADDR_W   = 10,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clka,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       perf_fetched,
    output logic [15:0]       perf_stall
`endif
);

    localparam int DEPTH = 2;

    logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic              inflight_reg, inflight_next;
    logic [ADDR_W-1:0] inflight_pc_reg, inflight_pc_next;
    logic [1:0]        count_reg, count_next;
    logic              wr_ptr_reg, wr_ptr_next;
    logic              rd_ptr_reg, rd_ptr_next;

    logic [ADDR_W-1:0] entry_pc   [DEPTH];
    logic [DATA_W-1:0] entry_data [DEPTH];

    logic       pop;
    logic       push;
    logic       issue;
    logic [2:0] occupancy;

    assign pop       = instr_valid & instr_ready;
    // A returning word is only kept when no flush happens in the same cycle.
    assign push      = inflight_reg & ~redirect;
    assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign issue     = ~redirect & ~halt & (occupancy < 3'd2);

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        inflight_next    = inflight_reg;
        inflight_pc_next = inflight_pc_reg;
        count_next       = count_reg;
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        if (redirect) begin
            fetch_pc_next = redirect_pc;
            inflight_next = 1'b0;
            count_next    = 2'd0;
            wr_ptr_next   = 1'b0;
            rd_ptr_next   = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_next = ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_next = ~rd_ptr_reg;
            end
            count_next    = count_reg + 2'(push) - 2'(pop);
            inflight_next = issue;
            if (issue) begin
                inflight_pc_next = fetch_pc_reg;
                fetch_pc_next    = fetch_pc_reg + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            count_reg       <= 2'd0;
            wr_ptr_reg      <= 1'b0;
            rd_ptr_reg      <= 1'b0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            inflight_reg    <= inflight_next;
            inflight_pc_reg <= inflight_pc_next;
            count_reg       <= count_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [ADDR_W-1:0] pc_reg;
            logic [DATA_W-1:0] data_reg;

            always_ff @(posedge clka) begin
                if (rst) begin
                    pc_reg   <= '0;
                    data_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    pc_reg   <= inflight_pc_reg;
                    data_reg <= mem_rdata;
                end
            end

            assign entry_pc[gi]   = pc_reg;
            assign entry_data[gi] = data_reg;
        end
    endgenerate

    assign mem_addr    = fetch_pc_reg;
    assign instr       = entry_data[rd_ptr_reg];
    assign instr_pc    = entry_pc[rd_ptr_reg];
    assign instr_valid = (count_reg != 2'd0);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched_reg;
    logic [15:0] perf_stall_reg;

    // Only reset clears these; a redirect leaves the history intact.
    always_ff @(posedge clka) begin
        if (rst) begin
            perf_fetched_reg <= 16'd0;
            perf_stall_reg   <= 16'd0;
        end else begin
            if (pop && (perf_fetched_reg != 16'hFFFF)) begin
                perf_fetched_reg <= perf_fetched_reg + 16'd1;
            end
            if (instr_valid && !instr_ready && (perf_stall_reg != 16'hFFFF)) begin
                perf_stall_reg <= perf_stall_reg + 16'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_stall   = perf_stall_reg;
`endif

endmodule
